// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: buffers completed memory reads in a DEPTH-entry FIFO,
// optionally byte-swapping on entry, and presents the head word to decode.
module instr_fetch_queue #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter bit          BYTE_SWAP = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          mem_in,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic                       flush,
  output logic [DATA_W-1:0]          instruction,
  output logic                       valid_r,
  input  logic                       take,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_overflow
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = $clog2(DEPTH + 1);
  localparam int unsigned NumBytes = DATA_W / 8;

  logic [DATA_W-1:0] storage_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              push, pop;
  logic [DATA_W-1:0] push_data;

  always_comb begin
    push_data = mem_in;
    if (BYTE_SWAP) begin
      for (int i = 0; i < int'(NumBytes); i++) begin
        push_data[8*i +: 8] = mem_in[8*(int'(NumBytes)-1-i) +: 8];
      end
    end
  end

  // Ready depends only on registered occupancy; a pop never frees a slot early.
  assign mem_ready    = (count_q != CntW'(DEPTH));
  assign valid_r      = (count_q != '0);
  assign push         = mem_valid & mem_ready & ~flush;
  assign pop          = take & valid_r & ~flush;
  assign count        = count_q;
  assign err_overflow = err_q;
  assign instruction  = valid_r ? storage_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | (mem_valid & ~mem_ready & ~flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; occupancy gates everything that reads it.
  always_ff @(posedge clk) begin
    if (push) storage_q[wr_ptr_q] <= push_data;
  end

endmodule
